// File: rtl/matmul_sequencer.sv
// 2x2 matmul sequencer: walks entry_out 0..7, multiplies and accumulates element pairs into a packed result.
// Latency: 8 cycles from start to a one-cycle done pulse. No backpressure: start is ignored while busy.
// Optional abort input enabled by defining MATMUL_ABORT_EN.
module matmul_sequencer #(
    parameter int ELEM_W = 3,
    parameter int RES_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef MATMUL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [ELEM_W-1:0]    element_a,
    input  logic [ELEM_W-1:0]    element_b,
    output logic [3:0]           entry_out,
    output logic                 busy,
    output logic                 done,
    output logic [4*RES_W-1:0]   result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] ENTRY_IDLE = 4'd8;

    state_t                  state_q, state_d;
    logic [3:0]              entry_q, entry_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [RES_W-1:0]        acc_q, acc_d;
    logic [2:0][RES_W-1:0]   part_q, part_d;
    logic [4*RES_W-1:0]      result_q, result_d;

    logic [RES_W-1:0]        prod;
    logic [RES_W-1:0]        sum;
    logic                    abort_req;

`ifdef MATMUL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Elements present now belong to the index issued on the previous edge, i.e. entry_q.
    assign prod = RES_W'(element_a) * RES_W'(element_b);
    assign sum  = acc_q + prod;

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        part_d   = part_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    entry_d = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    entry_d = ENTRY_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    entry_d = entry_q + 4'd1;
                    if (!entry_q[0]) begin
                        acc_d = prod;
                    end else if (entry_q == 4'd7) begin
                        result_d = {sum, part_q[2], part_q[1], part_q[0]};
                        entry_d  = ENTRY_IDLE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        case (entry_q[2:1])
                            2'd0:    part_d[0] = sum;
                            2'd1:    part_d[1] = sum;
                            2'd2:    part_d[2] = sum;
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_d = IDLE;
                entry_d = ENTRY_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            entry_q  <= ENTRY_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            part_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            part_q   <= part_d;
            result_q <= result_d;
        end
    end

    assign entry_out = entry_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: models the falling-edge element selectors, scoreboards results on done.
module tb_matmul_sequencer;

    localparam int ELEM_W = 3;
    localparam int RES_W  = 7;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
`ifdef MATMUL_ABORT_EN
    logic                abort = 1'b0;
`endif
    logic [ELEM_W-1:0]   element_a = '0;
    logic [ELEM_W-1:0]   element_b = '0;
    logic [3:0]          entry_out;
    logic                busy;
    logic                done;
    logic [4*RES_W-1:0]  result;

    int n_vec = 0;
    int n_err = 0;

    logic [ELEM_W-1:0]  a_ent [8];
    logic [ELEM_W-1:0]  b_ent [8];
    logic [4*RES_W-1:0] exp_q [$];

    matmul_sequencer #(.ELEM_W(ELEM_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef MATMUL_ABORT_EN
        .abort     (abort),
`endif
        .element_a (element_a),
        .element_b (element_b),
        .entry_out (entry_out),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Selector model: registers the element for the current index on the falling edge.
    always @(negedge clk) begin
        if (entry_out < 4'd8) begin
            element_a = a_ent[entry_out[2:0]];
            element_b = b_ent[entry_out[2:0]];
        end else begin
            element_a = '0;
            element_b = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                chk("result_on_done", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [4*RES_W-1:0] pack(input int c3, input int c2, input int c1, input int c0);
        return {RES_W'(c3), RES_W'(c2), RES_W'(c1), RES_W'(c0)};
    endfunction

    task automatic load_basic();
        int av[4] = '{1, 3, 2, 0};
        int bv[8] = '{2, 4, 5, 6, 1, 7, 3, 3};
        for (int k = 0; k < 8; k++) begin
            a_ent[k] = ELEM_W'(av[(k & 1) | ((k >> 2) << 1)]);
            b_ent[k] = ELEM_W'(bv[k]);
        end
    endtask

    task automatic load_const(input int v);
        for (int k = 0; k < 8; k++) begin
            a_ent[k] = ELEM_W'(v);
            b_ent[k] = ELEM_W'(v);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after done rises.
    task automatic do_run(input logic [4*RES_W-1:0] exp, input logic [4*RES_W-1:0] prev,
                          input bit keep_start);
        exp_q.push_back(exp);
        start = 1'b1;
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("run_entry_out", 32'(entry_out), 32'(k));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_result_hold", 32'(result), 32'(prev));
            chk("run_no_done", 32'(done), 32'd0);
            if (k == 3) start = 1'b1;
            @(negedge clk);
            if (k == 3 && !keep_start) start = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_entry_idle", 32'(entry_out), 32'd8);
        chk("done_busy_low", 32'(busy), 32'd0);
        if (!keep_start) begin
            @(negedge clk);
            chk("done_falls", 32'(done), 32'd0);
            chk("idle_entry", 32'(entry_out), 32'd8);
        end
    endtask

    // Starts a run and stops on the falling edge where entry_out equals stop_at.
    task automatic partial_run(input int stop_at, input logic [4*RES_W-1:0] prev);
        exp_q.push_back('0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < stop_at; k++) begin
            chk("partial_entry", 32'(entry_out), 32'(k));
            chk("partial_result_hold", 32'(result), 32'(prev));
            @(negedge clk);
        end
        chk("partial_entry", 32'(entry_out), 32'(stop_at));
        void'(exp_q.pop_back());
    endtask

    logic [4*RES_W-1:0] r_basic, r_max;

    initial begin
        r_basic = pack(6, 2, 23, 14);
        r_max   = pack(98, 98, 98, 98);
        load_basic();

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_entry", 32'(entry_out), 32'd8);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_hold_entry", 32'(entry_out), 32'd8);
            chk("idle_hold_busy", 32'(busy), 32'd0);
            chk("idle_hold_result", 32'(result), 32'd0);
        end

        do_run(r_basic, '0, 1'b0);

        load_const(7);
        do_run(r_max, r_basic, 1'b0);

        // Back-to-back with start held high: run 2 begins straight from DONE.
        load_basic();
        do_run(r_basic, r_max, 1'b1);
        load_const(7);
        do_run(r_max, r_basic, 1'b0);

        // Reset mid-run at entry_out=5.
        load_basic();
        partial_run(5, r_max);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_entry", 32'(entry_out), 32'd8);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        chk("midrst_quiet", 32'(done), 32'd0);
        do_run(r_basic, '0, 1'b0);

`ifdef MATMUL_ABORT_EN
        load_const(7);
        partial_run(3, r_basic);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_entry", 32'(entry_out), 32'd8);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result_kept", 32'(result), 32'(r_basic));
        @(negedge clk);
        chk("abort_quiet", 32'(done), 32'd0);

        partial_run(2, r_basic);
        abort = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        reset = 1'b0;
        chk("abort_rst_entry", 32'(entry_out), 32'd8);
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_result", 32'(result), 32'd0);
        do_run(r_max, '0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
